// File: rtl/data_ram_pipe.sv
// Parametrised data RAM behind the MEM stage.
// Byte-masked, write-first, zero-filled after reset, range-checked.
module data_ram_pipe #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 10,
  parameter int DEPTH          = 1024,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic                memRead,
  input  logic                memWrite,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   writeData,
  input  logic [DATA_W/8-1:0] byteEn,
  output logic                ready,
  output logic [DATA_W-1:0]   readData,
  output logic                readValid,
  output logic                addrErr,
  output logic                initDone
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t stateQ, stateD;
  logic [IDX_W-1:0] cntQ, cntD;
  logic readyQ, initDoneQ;
  logic clrWe;

  logic [DATA_W-1:0] mem [DEPTH];

  logic accept, inRange, doWrite;
  logic [IDX_W-1:0] idx;
  logic [DATA_W-1:0] oldWord, merged, rdWord;

  logic rv1Q, aeQ;
  logic [DATA_W-1:0] rd1Q;

  // Fill sequencing: walk every word once, then run forever.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    clrWe  = 1'b0;
    unique case (stateQ)
      CLEAR: begin
        clrWe = 1'b1;
        cntD  = cntQ + 1'b1;
        if (32'(cntQ) == DEPTH - 1) begin
          stateD = RUN;
          cntD   = '0;
        end
      end
      RUN: begin
        stateD = RUN;
      end
      default: stateD = RUN;
    endcase
  end

  // State, fill counter and the registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cntQ      <= '0;
      readyQ    <= 1'b0;
      initDoneQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      cntQ      <= cntD;
      readyQ    <= (stateD == RUN);
      initDoneQ <= (stateD == RUN);
    end
  end

  assign accept  = cs && readyQ && (memRead || memWrite);
  assign inRange = 32'(address) < DEPTH;
  assign idx     = address[IDX_W-1:0];
  assign doWrite = accept && memWrite && inRange;

  // Merge write bytes over the stored word; reads see the merged result.
  always_comb begin
    oldWord = mem[idx];
    merged  = oldWord;
    for (int i = 0; i < BYTES; i++) begin
      if (memWrite && byteEn[i]) begin
        merged[8*i +: 8] = writeData[8*i +: 8];
      end
    end
    rdWord = inRange ? merged : '0;
  end

  // Storage array: fill writes during CLEAR, masked writes in RUN.
  always_ff @(posedge clk) begin
    if (clrWe) begin
      mem[cntQ] <= '0;
    end else if (doWrite) begin
      mem[idx] <= merged;
    end
  end

  // First read stage plus the range-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv1Q <= 1'b0;
      rd1Q <= '0;
      aeQ  <= 1'b0;
    end else begin
      rv1Q <= accept && memRead;
      aeQ  <= accept && !inRange;
      if (accept && memRead) begin
        rd1Q <= rdWord;
      end
    end
  end

  assign addrErr  = aeQ;
  assign ready    = readyQ;
  assign initDone = initDoneQ;

  if (READ_LAT == 2) begin : gLat2
    logic rv2Q;
    logic [DATA_W-1:0] rd2Q;

    // Optional output register; data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rv2Q <= 1'b0;
        rd2Q <= '0;
      end else begin
        rv2Q <= rv1Q;
        if (rv1Q) begin
          rd2Q <= rd1Q;
        end
      end
    end

    assign readValid = rv2Q;
    assign readData  = rd2Q;
  end else begin : gLat1
    assign readValid = rv1Q;
    assign readData  = rd1Q;
  end

endmodule

// File: tb/tb_data_ram_pipe.sv
// Scoreboard bench for data_ram_pipe.
// Two instances: 1024 words/lat 1 and 1000 words/lat 2.
module tb_data_ram_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b0;
  logic memRead = 1'b0;
  logic memWrite = 1'b0;
  logic [9:0] address = '0;
  logic [63:0] writeData = '0;
  logic [7:0] byteEn = '0;

  logic ready [2];
  logic readValid [2];
  logic addrErr [2];
  logic initDone [2];
  logic [63:0] readData [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gDut
    data_ram_pipe #(
      .DATA_W(64),
      .ADDR_W(10),
      .DEPTH(g == 0 ? 1024 : 1000),
      .READ_LAT(g == 0 ? 1 : 2),
      .CLEAR_ON_RESET(1)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cs(cs),
      .memRead(memRead),
      .memWrite(memWrite),
      .address(address),
      .writeData(writeData),
      .byteEn(byteEn),
      .ready(ready[g]),
      .readData(readData[g]),
      .readValid(readValid[g]),
      .addrErr(addrErr[g]),
      .initDone(initDone[g])
    );
  end

  typedef struct {
    int k;
    int due;
    logic [63:0] d;
  } exp_t;

  exp_t rdQ[$];
  exp_t aeQ[$];
  logic [63:0] mdl [2][1024];
  int cnt [2];
  logic [63:0] lastData [2];
  int cyc = 0;
  int nVec = 0;
  int nErr = 0;

  task automatic check(input string tag, input int k,
                       input logic [63:0] got,
                       input logic [63:0] want);
    nVec++;
    if (got !== want) begin
      nErr++;
      $display("FAIL %s[%0d] cyc %0d: got %h want %h",
               tag, k, cyc, got, want);
    end
  endtask

  task automatic step(input int k);
    int depth;
    int lat;
    int qi;
    bit prevRdy;
    bit expV;
    logic [63:0] w;
    exp_t e;
    depth = (k == 0) ? 1024 : 1000;
    lat = (k == 0) ? 1 : 2;
    if (!rst_n) begin
      for (int i = rdQ.size() - 1; i >= 0; i--)
        if (rdQ[i].k == k) rdQ.delete(i);
      for (int i = aeQ.size() - 1; i >= 0; i--)
        if (aeQ[i].k == k) aeQ.delete(i);
      cnt[k] = 0;
      lastData[k] = '0;
      for (int a = 0; a < 1024; a++) mdl[k][a] = '0;
      check("rstReady", k, ready[k], 0);
      check("rstValid", k, readValid[k], 0);
      check("rstErr", k, addrErr[k], 0);
      check("rstInit", k, initDone[k], 0);
      check("rstData", k, readData[k], 0);
      return;
    end
    prevRdy = cnt[k] >= depth;
    if (cnt[k] < depth) cnt[k]++;
    if (prevRdy && cs && (memRead || memWrite)) begin
      if (int'(address) < depth) begin
        w = mdl[k][address];
        if (memWrite)
          for (int b = 0; b < 8; b++)
            if (byteEn[b]) w[8*b +: 8] = writeData[8*b +: 8];
        mdl[k][address] = w;
      end else begin
        w = '0;
        e.k = k; e.due = cyc; e.d = '0;
        aeQ.push_back(e);
      end
      if (memRead) begin
        e.k = k; e.due = cyc + lat - 1; e.d = w;
        rdQ.push_back(e);
      end
    end
    qi = -1;
    foreach (rdQ[i]) if (qi < 0 && rdQ[i].k == k) qi = i;
    expV = (qi >= 0) && (rdQ[qi].due == cyc);
    check("readValid", k, readValid[k], expV);
    if (expV) begin
      lastData[k] = rdQ[qi].d;
      rdQ.delete(qi);
    end
    check("readData", k, readData[k], lastData[k]);
    qi = -1;
    foreach (aeQ[i]) if (qi < 0 && aeQ[i].k == k) qi = i;
    expV = (qi >= 0) && (aeQ[qi].due == cyc);
    check("addrErr", k, addrErr[k], expV);
    if (expV) aeQ.delete(qi);
    check("ready", k, ready[k], cnt[k] >= depth);
    check("initDone", k, initDone[k], cnt[k] >= depth);
  endtask

  // Scoreboard: model acceptance and compare every cycle.
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) step(k);
  end

  task automatic drv(input bit c, input bit r, input bit w,
                     input int a, input logic [63:0] d,
                     input logic [7:0] be);
    @(negedge clk);
    cs = c;
    memRead = r;
    memWrite = w;
    address = a[9:0];
    writeData = d;
    byteEn = be;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, 0, 0, 0, 64'h0, 8'h0);
  endtask

  initial begin
    int a;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(290);
    drv(1, 1, 0, 49, 64'h0, 8'h0);
    drv(1, 0, 1, 3, 64'hFFFF_0000_FFFF_0000, 8'hFF);
    idle(6);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    idle(1030);
    drv(1, 1, 0, 49, 64'h0, 8'h0);
    drv(1, 0, 1, 48, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    drv(1, 0, 1, 48, 64'h1122_3344_5566_7788, 8'h0F);
    drv(1, 1, 0, 48, 64'h0, 8'h0);
    drv(1, 1, 1, 10, 64'hDEAD_BEEF, 8'hFF);
    drv(1, 1, 0, 10, 64'h0, 8'h0);
    drv(1, 0, 1, 48, 64'h0, 8'h00);
    drv(1, 1, 0, 48, 64'h0, 8'h0);
    drv(1, 0, 1, 5, 64'hA, 8'hFF);
    drv(1, 0, 1, 6, 64'hB, 8'hFF);
    drv(1, 1, 0, 5, 64'h0, 8'h0);
    drv(1, 1, 0, 6, 64'h0, 8'h0);
    idle(4);
    drv(1, 0, 1, 1010, 64'h5555_AAAA_5555_AAAA, 8'hFF);
    drv(1, 1, 0, 1010, 64'h0, 8'h0);
    drv(1, 0, 1, 999, 64'h0123_4567_89AB_CDEF, 8'hF0);
    drv(1, 1, 0, 999, 64'h0, 8'h0);
    drv(1, 1, 1, 1000, 64'h77, 8'h01);
    drv(1, 1, 0, 1023, 64'h0, 8'h0);
    drv(0, 1, 1, 7, 64'h99, 8'hFF);
    drv(1, 0, 0, 7, 64'h98, 8'hFF);
    drv(1, 1, 0, 7, 64'h0, 8'h0);
    idle(3);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) != 0) a = $urandom_range(990, 1023);
      else a = $urandom_range(0, 15);
      drv($urandom_range(0, 4) != 0, $urandom_range(0, 1) != 0,
          $urandom_range(0, 1) != 0, a,
          {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
    end
    idle(3);
    drv(1, 1, 0, 5, 64'h0, 8'h0);
    drv(1, 1, 0, 6, 64'h0, 8'h0);
    @(negedge clk);
    cs = 1'b0;
    memRead = 1'b0;
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    idle(1030);
    drv(1, 1, 0, 48, 64'h0, 8'h0);
    drv(1, 1, 0, 5, 64'h0, 8'h0);
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
